// File: rtl/instr_fetch_unit_if.sv
// Bus bundles of the fetch unit: instruction-memory request channel and
// the decode-side instruction stream.
interface instr_fetch_unit_imem_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

interface instr_fetch_unit_dec_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opc;

    modport master (
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc,
        output opc
    );

    modport slave (
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc,
        input  opc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// RISC-V fetch front end: PC owner, single-outstanding imem requester and a
// small instruction buffer feeding decode, with redirect/flush support.
module instr_fetch_unit_chk #(
    parameter int unsigned CNT_W = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic full_i,
    input  logic push_i,
    input  logic pop_i
);
    a_no_push_when_full: assert property (@(posedge clock) disable iff (!reset_n)
        !(full_i && push_i && pop_i) && !(full_i && push_i));
endmodule

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           redirect,
    input  logic [31:0]                    redirect_pc,
    instr_fetch_unit_imem_if.master        imem,
    instr_fetch_unit_dec_if.master         dec
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        tag_q, tag_d;
    logic [31:0]        data_q [DEPTH];
    logic [31:0]        pcs_q  [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   occ_after_s;
    logic               push_s, pop_s, grant_s, req_s, valid_s;
    logic               redirect_lsb_unused_s;

    assign redirect_lsb_unused_s = ^redirect_pc[1:0];

    // Push/pop are suppressed during a redirect because the buffer is flushed.
    assign valid_s     = (count_q != CNT_W'(0));
    assign push_s      = (state_q == ST_WAIT) && imem.imem_rvalid && !redirect;
    assign pop_s       = valid_s && dec.instr_ready && !redirect;
    assign occ_after_s = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    assign count_d     = occ_after_s;
    assign grant_s     = req_s && imem.imem_gnt;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect) begin
            if (grant_s) begin
                state_d = ST_DROP;
            end else if ((state_q != ST_IDLE) && !imem.imem_rvalid) begin
                state_d = ST_DROP;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_IDLE: state_d = grant_s ? ST_WAIT : ST_IDLE;
                ST_WAIT: state_d = imem.imem_rvalid ? (grant_s ? ST_WAIT : ST_IDLE) : ST_WAIT;
                ST_DROP: state_d = imem.imem_rvalid ? (grant_s ? ST_WAIT : ST_IDLE) : ST_DROP;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        req_s = 1'b0;
        if (!reset_n) begin
            req_s = 1'b0;
        end else if (((state_q == ST_IDLE) || ((state_q == ST_WAIT) && imem.imem_rvalid))
                     && (occ_after_s < DEPTH_C)) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
    end

    always_comb begin
        pc_d  = pc_q;
        tag_d = tag_q;
        if (redirect) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end else if (grant_s) begin
            pc_d = pc_q + 32'd4;
        end else begin
            pc_d = pc_q;
        end
        if (grant_s) begin
            tag_d = pc_q;
        end else begin
            tag_d = tag_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc_q     <= RESET_PC;
            tag_q    <= 32'h0;
            rd_ptr_q <= PTR_W'(0);
            wr_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= 32'h0;
                pcs_q[i]  <= 32'h0;
            end
        end else begin
            pc_q  <= pc_d;
            tag_q <= tag_d;
            if (redirect) begin
                rd_ptr_q <= PTR_W'(0);
                wr_ptr_q <= PTR_W'(0);
                count_q  <= CNT_W'(0);
            end else begin
                if (push_s) begin
                    data_q[wr_ptr_q] <= imem.imem_rdata;
                    pcs_q[wr_ptr_q]  <= tag_q;
                    wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
                end
                if (pop_s) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
                count_q <= count_d;
            end
        end
    end

    assign imem.imem_req   = req_s;
    assign imem.imem_addr  = pc_q;
    assign dec.instr_valid = valid_s;
    assign dec.instr       = data_q[rd_ptr_q];
    assign dec.instr_pc    = pcs_q[rd_ptr_q];
    assign dec.opc         = data_q[rd_ptr_q][6:0];

    instr_fetch_unit_chk #(.CNT_W(CNT_W)) u_chk (
        .clock   (clock),
        .reset_n (reset_n),
        .full_i  (count_q == DEPTH_C),
        .push_i  (push_s),
        .pop_i   (pop_s)
    );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a vector table for streaming and
// backpressure, plus hand sequences for redirect, grant stall, wrap and reset.
module tb_instr_fetch_unit;
    logic        clock;
    logic        reset_n;
    logic        redirect;
    logic [31:0] redirect_pc;

    instr_fetch_unit_imem_if imem_bus ();
    instr_fetch_unit_dec_if  dec_bus ();

    instr_fetch_unit #(.RESET_PC(32'h0040_0000), .DEPTH(2)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem_bus),
        .dec         (dec_bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          rst_before;
        bit          gnt;
        bit          rdy;
        bit          exp_req;
        logic [31:0] exp_addr;
        bit          exp_vld;
        logic [31:0] exp_pc;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // memory model: one pending read, answered mem_lat cycles after grant
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'h0;
    int          mem_lat = 1;
    logic [31:0] mem_xor = 32'h0;

    logic        s_req, s_valid;
    logic [31:0] s_addr, s_instr, s_pc;
    logic [6:0]  s_opc;

    function automatic vec_t mk(bit r, bit g, bit y, bit eq, logic [31:0] ea, bit ev, logic [31:0] ep);
        vec_t v;
        v.rst_before = r; v.gnt = g; v.rdy = y;
        v.exp_req = eq; v.exp_addr = ea; v.exp_vld = ev; v.exp_pc = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        bit took;
        imem_bus.imem_rvalid = pend && (pend_cnt == 1);
        imem_bus.imem_rdata  = imem_bus.imem_rvalid ? (pend_addr ^ mem_xor) : 32'h0;
        #1;
        s_req   = imem_bus.imem_req;
        s_addr  = imem_bus.imem_addr;
        s_valid = dec_bus.instr_valid;
        s_instr = dec_bus.instr;
        s_pc    = dec_bus.instr_pc;
        s_opc   = dec_bus.opc;
        took    = s_req && imem_bus.imem_gnt;
        @(posedge clock);
        if (imem_bus.imem_rvalid) pend = 1'b0;
        else if (pend) pend_cnt = pend_cnt - 1;
        if (took) begin
            pend      = 1'b1;
            pend_cnt  = mem_lat;
            pend_addr = s_addr;
        end
        @(negedge clock);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " rst req"},   {31'h0, s_req},   32'h0);
        chk({tag, " rst valid"}, {31'h0, s_valid}, 32'h0);
        chk({tag, " rst instr"}, s_instr,          32'h0);
        chk({tag, " rst pc"},    s_pc,             32'h0);
        chk({tag, " rst opc"},   {25'h0, s_opc},   32'h0);
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_bus.imem_gnt = 1'b0; dec_bus.instr_ready = 1'b0;
        pend = 1'b0; mem_lat = 1; mem_xor = 32'h0;
        step();
        step();
        chk_reset_outputs(tag);
        reset_n = 1'b1;
    endtask

    // run until the first valid head; reports whether one appeared in time
    task automatic wait_valid(input int budget, output bit found);
        found = 1'b0;
        for (int k = 0; k < budget && !found; k++) begin
            step();
            if (s_valid) found = 1'b1;
        end
    endtask

    vec_t vecs [15];

    initial begin
        bit          found;
        bit          got_addr;
        logic [31:0] first_addr;

        reset_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_bus.imem_gnt = 1'b0; imem_bus.imem_rvalid = 1'b0; imem_bus.imem_rdata = 32'h0;
        dec_bus.instr_ready = 1'b0;

        // streaming at one instruction per cycle
        vecs[0]  = mk(1, 1, 1, 1, 32'h0040_0000, 0, 32'h0);
        vecs[1]  = mk(0, 1, 1, 1, 32'h0040_0004, 0, 32'h0);
        vecs[2]  = mk(0, 1, 1, 1, 32'h0040_0008, 1, 32'h0040_0000);
        vecs[3]  = mk(0, 1, 1, 1, 32'h0040_000C, 1, 32'h0040_0004);
        vecs[4]  = mk(0, 1, 1, 1, 32'h0040_0010, 1, 32'h0040_0008);
        // backpressure for six cycles, then resume
        vecs[5]  = mk(1, 1, 0, 1, 32'h0040_0000, 0, 32'h0);
        vecs[6]  = mk(0, 1, 0, 1, 32'h0040_0004, 0, 32'h0);
        vecs[7]  = mk(0, 1, 0, 0, 32'h0,         1, 32'h0040_0000);
        vecs[8]  = mk(0, 1, 0, 0, 32'h0,         1, 32'h0040_0000);
        vecs[9]  = mk(0, 1, 0, 0, 32'h0,         1, 32'h0040_0000);
        vecs[10] = mk(0, 1, 0, 0, 32'h0,         1, 32'h0040_0000);
        vecs[11] = mk(0, 1, 1, 1, 32'h0040_0008, 1, 32'h0040_0000);
        vecs[12] = mk(0, 1, 1, 1, 32'h0040_000C, 1, 32'h0040_0004);
        vecs[13] = mk(0, 1, 1, 1, 32'h0040_0010, 1, 32'h0040_0008);
        vecs[14] = mk(0, 1, 1, 1, 32'h0040_0014, 1, 32'h0040_000C);

        @(negedge clock);
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].rst_before) do_reset($sformatf("v%0d", i));
            imem_bus.imem_gnt   = vecs[i].gnt;
            dec_bus.instr_ready = vecs[i].rdy;
            step();
            chk($sformatf("v%0d req", i),   {31'h0, s_req},   {31'h0, vecs[i].exp_req});
            if (vecs[i].exp_req) chk($sformatf("v%0d addr", i), s_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d valid", i), {31'h0, s_valid}, {31'h0, vecs[i].exp_vld});
            if (vecs[i].exp_vld) begin
                chk($sformatf("v%0d pc", i),    s_pc,           vecs[i].exp_pc);
                chk($sformatf("v%0d instr", i), s_instr,        vecs[i].exp_pc);
                chk($sformatf("v%0d opc", i),   {25'h0, s_opc}, {25'h0, vecs[i].exp_pc[6:0]});
            end
        end

        // redirect while a slow response is outstanding
        do_reset("redir1");
        mem_lat = 3; imem_bus.imem_gnt = 1'b1; dec_bus.instr_ready = 1'b1;
        step();
        redirect = 1'b1; redirect_pc = 32'h0040_0103;
        step();
        redirect = 1'b0; mem_lat = 1;
        got_addr = 1'b0; first_addr = 32'h0; found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (s_req && !got_addr) begin got_addr = 1'b1; first_addr = s_addr; end
            if (s_valid) found = 1'b1;
        end
        chk("redir1 req seen",   {31'h0, got_addr}, 32'h1);
        chk("redir1 next addr",  first_addr,        32'h0040_0100);
        chk("redir1 vld seen",   {31'h0, found},    32'h1);
        chk("redir1 first pc",   s_pc,              32'h0040_0100);
        chk("redir1 first data", s_instr,           32'h0040_0100);

        // redirect coinciding with rvalid while one entry is buffered
        do_reset("redir2");
        imem_bus.imem_gnt = 1'b1; dec_bus.instr_ready = 1'b0;
        step();
        step();
        imem_bus.imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h0040_0200;
        step();
        chk("redir2 one entry", {31'h0, s_valid}, 32'h1);
        redirect = 1'b0; imem_bus.imem_gnt = 1'b1; dec_bus.instr_ready = 1'b1;
        step();
        chk("redir2 flushed",  {31'h0, s_valid}, 32'h0);
        chk("redir2 req",      {31'h0, s_req},   32'h1);
        chk("redir2 addr",     s_addr,           32'h0040_0200);
        wait_valid(10, found);
        chk("redir2 vld seen", {31'h0, found},   32'h1);
        chk("redir2 first pc", s_pc,             32'h0040_0200);

        // grant stall: request and address held until granted
        do_reset("stall");
        imem_bus.imem_gnt = 1'b0; dec_bus.instr_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("stall%0d req", k),  {31'h0, s_req}, 32'h1);
            chk($sformatf("stall%0d addr", k), s_addr,         32'h0040_0000);
        end
        imem_bus.imem_gnt = 1'b1;
        step();
        chk("stall gnt addr", s_addr, 32'h0040_0000);
        step();
        chk("stall next req",  {31'h0, s_req}, 32'h1);
        chk("stall next addr", s_addr,         32'h0040_0004);

        // PC wrap at the top of the address space
        do_reset("wrap");
        imem_bus.imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0; imem_bus.imem_gnt = 1'b1; dec_bus.instr_ready = 1'b1;
        step();
        chk("wrap addr0", s_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap req1",  {31'h0, s_req}, 32'h1);
        chk("wrap addr1", s_addr,         32'h0000_0000);
        step();
        chk("wrap vld0", {31'h0, s_valid}, 32'h1);
        chk("wrap pc0",  s_pc,             32'hFFFF_FFFC);
        chk("wrap opc0", {25'h0, s_opc},   32'h0000_007C);
        step();
        chk("wrap vld1", {31'h0, s_valid}, 32'h1);
        chk("wrap pc1",  s_pc,             32'h0000_0000);

        // reset during WAIT, stray response arriving after release
        do_reset("midrst pre");
        mem_lat = 3; imem_bus.imem_gnt = 1'b1; dec_bus.instr_ready = 1'b1;
        step();
        reset_n = 1'b0;
        step();
        step();
        chk_reset_outputs("midrst");
        reset_n = 1'b1; mem_lat = 1; mem_xor = 32'hDEAD_BEEF;
        step();
        chk("midrst req",  {31'h0, s_req}, 32'h1);
        chk("midrst addr", s_addr,         32'h0040_0000);
        mem_xor = 32'h0;
        wait_valid(10, found);
        chk("midrst vld seen", {31'h0, found}, 32'h1);
        chk("midrst pc",       s_pc,           32'h0040_0000);
        chk("midrst data",     s_instr,        32'h0040_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
